sfx_voice_mixer: RTL and testbench
==================================

# sfx_voice_mixer

Multi-voice sound-effect player that replaces the single-shot, single-voice sample player in the audio path. Each of NVOICES voices plays an 8-bit signed sample span, set by start and end addresses, from a shared sample ROM, optionally looping. Voices are summed with saturation and serialised to the external audio codec. The codec is the timing master and supplies LR and bit clocks; this block drives serial data only.

## Interface
Parameters:
- NVOICES, 4, number of independent voices (1..8)
- SAMPLE_W, 8, ROM sample width, two's complement
- OUT_W, 16, serial output word width (OUT_W ≥ SAMPLE_W)
- ADDR_W, 17, ROM address width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- audio_lr  in  1  codec LR clock (asynchronous)
- audio_clk  in  1  codec bit clock (asynchronous)
- audio_data  out  1  serial sample, MSB first
- trig  in  NVOICES  per-voice start request, level; a rising edge starts the voice
- loop  in  NVOICES  per-voice loop enable, sampled at trigger
- start_addr  in  NVOICES*ADDR_W  per-voice first sample address; voice i uses bits [i*ADDR_W +: ADDR_W]
- end_addr  in  NVOICES*ADDR_W  per-voice last sample address, inclusive
- rom_addr  out  ADDR_W  shared ROM read address
- rom_data  in  SAMPLE_W  ROM data, valid exactly 1 clk after rom_addr
- active  out  NVOICES  voice-playing flags

## Operation
- All asynchronous inputs (audio_lr, audio_clk, trig) pass through 2-flop synchronisers. Edges are detected on the synchronised values.
- **Voice state** (per voice): addr, end, loop_r, active.
  - A trig rising edge sets a pending bit. The pending bit is applied only while the sequencer is IDLE: addr←start, end←end_addr, loop_r←loop, active←1.
  - Retriggering an active voice restarts it.
- **Sequencer FSM** has states IDLE, ADDR, DATA, SAT.
  - IDLE→ADDR on each synchronised audio_lr falling transition. This marks the frame start and sets i=0, acc=0.
  - ADDR: rom_addr←addr[i]; go to DATA.
  - DATA: if active[i], acc += sign-extended rom_data << (OUT_W−SAMPLE_W). Then advance the voice:
    - if addr==end and loop_r: addr←start
    - if addr==end and not loop_r: active←0
    - otherwise: addr+1
  - DATA then goes to ADDR with i+1, or to SAT after the last voice. Inactive voices still take their ADDR/DATA slots, so timing is fixed.
  - SAT: mix←acc clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1]; go to IDLE.
  - The accumulator is OUT_W+3 bits wide, so it cannot overflow for any NVOICES ≤ 8.
- **Serialiser**: shift register sh of OUT_W+1 bits.
  - On every synchronised audio_lr transition (either edge): sh←{1'b0, mix}.
  - Otherwise, on a synchronised audio_clk falling edge: sh←sh<<1.
  - audio_data = sh[OUT_W]. This gives the I2S one-bit delay.
  - Both channels carry the same mix value.
- A trigger and an end-of-span on the same voice in the same frame: the trigger wins, because it is applied in IDLE after the span ended.

## Timing
- **Reset values**: audio_data=0, rom_addr=0, active=0, mix=0, sh=0, pending=0, FSM=IDLE. Reset mid-sequence or mid-word abandons it. The first post-reset frame outputs 0.
- **Synchroniser latency**: 2 clk to the synchronised value, plus 1 clk for the edge.
- **Sequencer duration**: 2·NVOICES+1 clk from frame start. It must complete before the next audio_lr transition, which holds when clk ≥ 64× the audio_lr rate.
- **Mix latency**: a mix computed in frame k is loaded at the audio_lr rising transition of frame k (right channel) and at the falling transition of frame k+1 (left channel).
- **Trigger latency**: a trigger takes effect for samples fetched in the first frame start after it is applied.
- **Sample rate**: each active voice advances exactly one sample per frame.

## Test plan
- Reset mid-word: assert reset_n=0 while audio_data is 1 → audio_data=0, active=0; the first frame after release shifts out 16 zeros.
- Single voice: NVOICES=2, ROM[10..12]={0x40, 0xC0, 0x01}, trig[0] pulse with start=10, end=12, loop=0 → left words 0x4000, 0xC000, 0x0100, then active[0]=0 and output 0x0000.
- Saturation: both voices on samples 0x7F → 0x7FFF (not 0xFE00); both voices on 0x80 → 0x8000.
- Loop: start=5, end=6, loop=1 → addresses 5, 6, 5, 6… for 10 frames; active stays 1.
- Retrigger: trig[1] re-pulsed mid-span and asserted during a sequencer run → restart at start_addr, applied after SAT with no lost or duplicated slot; active stays 1.
- Serial format: mix=0xA5F0 → audio_data stays 0 for 1 bclk after the LR edge, then shifts out 1010 0101 1111 0000, sampled on bclk rising edges.

Source files
------------

// File: rtl/sfx_voice_mixer.sv
// Multi-voice sample player: sequences NVOICES voices through a shared ROM once per
// codec frame, sums them with saturation and shifts the mix out in I2S format.
module sfx_voice_mixer #(
    parameter int NVOICES  = 4,
    parameter int SAMPLE_W = 8,
    parameter int OUT_W    = 16,
    parameter int ADDR_W   = 17
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      audio_lr,
    input  logic                      audio_clk,
    output logic                      audio_data,
    input  logic [NVOICES-1:0]        trig,
    input  logic [NVOICES-1:0]        loop,
    input  logic [NVOICES*ADDR_W-1:0] start_addr,
    input  logic [NVOICES*ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [SAMPLE_W-1:0]       rom_data,
    output logic [NVOICES-1:0]        active
);
    localparam int IW    = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam int ACC_W = OUT_W + 3;
    localparam logic [IW-1:0] LAST = IW'(NVOICES - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, SAT} state_t;

    // [1:0] form the synchroniser, [2] holds the previous synchronised value
    logic [2:0]                lr_q, bclk_q;
    logic [NVOICES-1:0]        trig_s1_q, trig_s2_q, trig_s3_q;

    state_t                    state_q;
    logic [IW-1:0]             idx_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [OUT_W-1:0]          mix_q;
    logic [ADDR_W-1:0]         rom_addr_q;
    logic [NVOICES-1:0]        pend_q, active_q, loop_q;
    logic [ADDR_W-1:0]         addr_q  [NVOICES];
    logic [ADDR_W-1:0]         start_q [NVOICES];
    logic [ADDR_W-1:0]         end_q   [NVOICES];
    logic [OUT_W:0]            sh_q;

    logic                      lr_fall, lr_edge, bclk_fall;
    logic [NVOICES-1:0]        trig_rise;
    logic [IW-1:0]             idx_nxt;
    logic signed [ACC_W-1:0]   samp_ext;
    logic [ACC_W-OUT_W:0]      acc_hi;

    assign lr_fall    = lr_q[2] & ~lr_q[1];
    assign lr_edge    = lr_q[2] ^ lr_q[1];
    assign bclk_fall  = bclk_q[2] & ~bclk_q[1];
    assign trig_rise  = trig_s2_q & ~trig_s3_q;
    assign idx_nxt    = idx_q + IW'(1);
    assign samp_ext   = ACC_W'(signed'(rom_data)) <<< (OUT_W - SAMPLE_W);
    assign acc_hi     = acc_q[ACC_W-1:OUT_W-1];

    assign audio_data = sh_q[OUT_W];
    assign rom_addr   = rom_addr_q;
    assign active     = active_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lr_q      <= '0;
            bclk_q    <= '0;
            trig_s1_q <= '0;
            trig_s2_q <= '0;
            trig_s3_q <= '0;
        end else begin
            lr_q      <= {lr_q[1:0], audio_lr};
            bclk_q    <= {bclk_q[1:0], audio_clk};
            trig_s1_q <= trig;
            trig_s2_q <= trig_s1_q;
            trig_s3_q <= trig_s2_q;
        end
    end

    // An LR transition reloads the word; the leading 0 gives the I2S one-bit delay
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_q <= '0;
        end else if (lr_edge) begin
            sh_q <= {1'b0, mix_q};
        end else if (bclk_fall) begin
            sh_q <= {sh_q[OUT_W-1:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            mix_q      <= '0;
            rom_addr_q <= '0;
            pend_q     <= '0;
            active_q   <= '0;
            loop_q     <= '0;
            for (int unsigned i = 0; i < NVOICES; i++) begin
                addr_q[i]  <= '0;
                start_q[i] <= '0;
                end_q[i]   <= '0;
            end
        end else begin
            pend_q <= pend_q | trig_rise;
            case (state_q)
                IDLE: begin
                    if (lr_fall) begin
                        state_q    <= ADDR;
                        idx_q      <= '0;
                        acc_q      <= '0;
                        rom_addr_q <= addr_q[0];
                    end else begin
                        // Triggers land only between sequencer runs, never on a frame-start cycle
                        pend_q <= trig_rise;
                        for (int unsigned i = 0; i < NVOICES; i++) begin
                            if (pend_q[i]) begin
                                addr_q[i]   <= start_addr[i*ADDR_W +: ADDR_W];
                                start_q[i]  <= start_addr[i*ADDR_W +: ADDR_W];
                                end_q[i]    <= end_addr[i*ADDR_W +: ADDR_W];
                                loop_q[i]   <= loop[i];
                                active_q[i] <= 1'b1;
                            end
                        end
                    end
                end
                ADDR: state_q <= DATA;
                DATA: begin
                    if (active_q[idx_q]) begin
                        acc_q <= acc_q + samp_ext;
                        if (addr_q[idx_q] == end_q[idx_q]) begin
                            if (loop_q[idx_q]) begin
                                addr_q[idx_q] <= start_q[idx_q];
                            end else begin
                                active_q[idx_q] <= 1'b0;
                            end
                        end else begin
                            addr_q[idx_q] <= addr_q[idx_q] + ADDR_W'(1);
                        end
                    end
                    if (idx_q == LAST) begin
                        state_q <= SAT;
                    end else begin
                        idx_q      <= idx_nxt;
                        rom_addr_q <= addr_q[idx_nxt];
                        state_q    <= ADDR;
                    end
                end
                SAT: begin
                    if ((&acc_hi) || !(|acc_hi)) begin
                        mix_q <= acc_q[OUT_W-1:0];
                    end else if (acc_q[ACC_W-1]) begin
                        mix_q <= {1'b1, {(OUT_W-1){1'b0}}};
                    end else begin
                        mix_q <= {1'b0, {(OUT_W-1){1'b1}}};
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sfx_voice_mixer.sv
// Directed bench for sfx_voice_mixer (NVOICES=2): frame-by-frame table of triggers and
// expected serial words, plus hand sequences for looping, retrigger and mid-word reset.
module tb_sfx_voice_mixer;
    localparam int NV = 2;
    localparam int AW = 17;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           audio_lr = 1'b1;
    logic           audio_clk = 1'b0;
    logic           audio_data;
    logic [NV-1:0]  trig = '0;
    logic [NV-1:0]  loop = '0;
    logic [AW-1:0]  s0 = '0, e0 = '0, s1 = '0, e1 = '0;
    logic [AW-1:0]  rom_addr;
    logic [7:0]     rom_data = '0;
    logic [NV-1:0]  active;
    logic [7:0]     rom [256];

    int checks = 0;
    int failures = 0;

    sfx_voice_mixer #(.NVOICES(NV), .SAMPLE_W(8), .OUT_W(16), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .audio_lr   (audio_lr),
        .audio_clk  (audio_clk),
        .audio_data (audio_data),
        .trig       (trig),
        .loop       (loop),
        .start_addr ({s1, s0}),
        .end_addr   ({e1, e0}),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .active     (active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr[7:0]];

    typedef struct {
        logic [1:0]  trg;
        logic [1:0]  lp;
        logic [16:0] vs0, ve0, vs1, ve1;
        logic [15:0] el, er;
        logic [1:0]  ea;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One channel: bit 0 is the I2S delay slot, then 16 data bits sampled on bclk rise
    task automatic shift_half(input logic lrv, output logic [15:0] w, output logic d0);
        audio_lr = lrv;
        w = '0;
        d0 = 1'b0;
        for (int b = 0; b < 17; b++) begin
            #60 audio_clk = 1'b1;
            if (b == 0) d0 = audio_data;
            else w = {w[14:0], audio_data};
            #60 audio_clk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [1:0] tmask, output logic [15:0] l,
                             output logic [15:0] r, output logic [1:0] d);
        logic dl, dr;
        trig = tmask;
        shift_half(1'b0, l, dl);
        trig = '0;
        shift_half(1'b1, r, dr);
        d = {dl, dr};
    endtask

    task automatic frame_check(input string tag, input logic [1:0] tmask,
                               input logic [15:0] el, input logic [15:0] er, input logic [1:0] ea);
        logic [15:0] l, r;
        logic [1:0]  d;
        run_frame(tmask, l, r, d);
        check({tag, "_left"}, 32'(l), 32'(el));
        check({tag, "_right"}, 32'(r), 32'(er));
        check({tag, "_active"}, 32'(active), 32'(ea));
        check({tag, "_delay_bits"}, 32'(d), 32'd0);
    endtask

    initial begin
        vec_t        vecs [13];
        logic [15:0] w;
        logic        d0;

        foreach (rom[i]) rom[i] = 8'h00;
        rom[10] = 8'h40; rom[11] = 8'hC0; rom[12] = 8'h01;
        rom[20] = 8'h7F; rom[21] = 8'h33; rom[30] = 8'h80;
        rom[5]  = 8'h11; rom[6]  = 8'h22; rom[40] = 8'hA5;

        //            trg    lp     s0  e0  s1  e1  left      right     active
        vecs[0]  = '{2'b00, 2'b00, 0,  0,  0,  0,  16'h0000, 16'h0000, 2'b00};
        vecs[1]  = '{2'b01, 2'b00, 10, 12, 0,  0,  16'h0000, 16'h4000, 2'b01};
        vecs[2]  = '{2'b00, 2'b00, 10, 12, 0,  0,  16'h4000, 16'hC000, 2'b01};
        vecs[3]  = '{2'b00, 2'b00, 10, 12, 0,  0,  16'hC000, 16'h0100, 2'b00};
        vecs[4]  = '{2'b01, 2'b00, 40, 40, 0,  0,  16'h0100, 16'hA500, 2'b00};
        vecs[5]  = '{2'b11, 2'b11, 20, 20, 20, 20, 16'hA500, 16'h7FFF, 2'b11};
        vecs[6]  = '{2'b00, 2'b11, 20, 20, 20, 20, 16'h7FFF, 16'h7FFF, 2'b11};
        vecs[7]  = '{2'b11, 2'b00, 30, 30, 30, 30, 16'h7FFF, 16'h8000, 2'b00};
        vecs[8]  = '{2'b10, 2'b10, 30, 30, 5,  6,  16'h8000, 16'h1100, 2'b10};
        vecs[9]  = '{2'b00, 2'b10, 30, 30, 5,  6,  16'h1100, 16'h2200, 2'b10};
        vecs[10] = '{2'b00, 2'b10, 30, 30, 5,  6,  16'h2200, 16'h1100, 2'b10};
        vecs[11] = '{2'b01, 2'b10, 10, 10, 5,  6,  16'h1100, 16'h6200, 2'b10};
        vecs[12] = '{2'b00, 2'b10, 10, 10, 5,  6,  16'h6200, 16'h1100, 2'b10};

        repeat (3) @(negedge clk);
        check("reset_audio_data", 32'(audio_data), 32'd0);
        check("reset_active", 32'(active), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        foreach (vecs[k]) begin
            s0 = vecs[k].vs0; e0 = vecs[k].ve0;
            s1 = vecs[k].vs1; e1 = vecs[k].ve1;
            loop = vecs[k].lp;
            trig = vecs[k].trg;
            repeat (5) @(negedge clk);
            trig = '0;
            repeat (5) @(negedge clk);
            frame_check($sformatf("vec%0d", k), 2'b00, vecs[k].el, vecs[k].er, vecs[k].ea);
        end

        // Voice 1 keeps looping 5,6,5,6...
        for (int f = 0; f < 8; f++) begin
            frame_check($sformatf("loop%0d", f), 2'b00,
                        (f % 2 == 0) ? 16'h1100 : 16'h2200,
                        (f % 2 == 0) ? 16'h2200 : 16'h1100, 2'b10);
        end

        // Retrigger raised together with the frame-start LR edge: current slot finishes, then restart
        s1 = 20; e1 = 21; loop = 2'b10;
        frame_check("retrig0", 2'b10, 16'h1100, 16'h2200, 2'b10);
        frame_check("retrig1", 2'b00, 16'h2200, 16'h7F00, 2'b10);
        frame_check("retrig2", 2'b00, 16'h7F00, 16'h3300, 2'b10);
        frame_check("retrig3", 2'b00, 16'h3300, 16'h7F00, 2'b10);

        // Reset while the 0x7F00 left word is shifting out a 1
        audio_lr = 1'b0;
        for (int b = 0; b < 3; b++) begin
            #60 audio_clk = 1'b1;
            if (b < 2) #60 audio_clk = 1'b0;
        end
        check("midword_data_high", 32'(audio_data), 32'd1);
        #10 reset_n = 1'b0;
        #1;
        check("midword_reset_data", 32'(audio_data), 32'd0);
        check("midword_reset_active", 32'(active), 32'd0);
        audio_clk = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        shift_half(1'b1, w, d0);
        frame_check("post_reset", 2'b00, 16'h0000, 16'h0000, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
